// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32I opcodes, 2-bit counter encodings and BTB entry layout.
package rv_pkg;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_t;
  // tag is sized for the smallest index; narrower tags are stored zero-extended
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
    ctr_t        ctr;
  } btb_entry_t;
  function automatic ctr_t ctr_next(ctr_t c, logic up);
    return up ? (c == ST ? ST : ctr_t'(c + 2'd1)) : (c == SNT ? SNT : ctr_t'(c - 2'd1));
  endfunction
endpackage

// File: rtl/branch_predict_unit_btb_table.sv
// btb_table: direct-mapped BTB storage, two async read ports, one write port.
module btb_table
  import rv_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_a,
  output btb_entry_t       rd_a,
  input  logic [IDX_W-1:0] rd_idx_b,
  output btb_entry_t       rd_b,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  btb_entry_t       wr_data
);
  btb_entry_t mem [2**IDX_W];
  assign rd_a = mem[rd_idx_a];
  assign rd_b = mem[rd_idx_b];
  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int i = 0; i < 2**IDX_W; i++) mem[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
    else if (wr_en)
      mem[wr_idx] <= wr_data;
endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: fetch PC, BTB prediction and EX-stage branch resolution.
module branch_predict_unit
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BTB_IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  output logic [31:0] if_pc,
  output logic        if_pred_taken,
  output logic [31:0] if_pred_target,
  input  logic        ex_valid,
  input  logic [6:0]  ex_op,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_rs1,
  input  logic        ex_zero,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        flush,
  output logic [31:0] br_count,
  output logic [31:0] mis_count
);
  btb_entry_t           if_e, ex_e, wr_e;
  logic                 if_hit, ex_hit, is_br, is_jalr, ctl, taken, mis, wr_en;
  logic [31:0]          target, next_pc;
  logic [BTB_IDX_W-1:0] if_idx, ex_idx;
  assign if_idx         = if_pc[BTB_IDX_W+1:2];
  assign ex_idx         = ex_pc[BTB_IDX_W+1:2];
  assign if_hit         = if_e.valid && if_e.tag == 30'(if_pc[31:BTB_IDX_W+2]);
  assign ex_hit         = ex_e.valid && ex_e.tag == 30'(ex_pc[31:BTB_IDX_W+2]);
  assign if_pred_taken  = if_hit && if_e.ctr[1];
  assign if_pred_target = if_hit ? if_e.target : if_pc + 32'd4;
  assign is_br          = ex_op == OP_BRANCH;
  assign is_jalr        = ex_op == OP_JALR;
  assign ctl            = ex_valid && (is_br || is_jalr || ex_op == OP_JAL);
  assign taken          = is_br ? ex_zero : 1'b1;
  assign target         = is_jalr ? (ex_rs1 + ex_imm) & ~32'd1 : ex_pc + ex_imm;
  assign mis            = ctl && (taken != ex_pred_taken || (taken && target != ex_pred_target));
  assign flush          = mis;
  assign next_pc        = mis ? (taken ? target : ex_pc + 32'd4) : stall ? if_pc : if_pred_target;
  // not-taken branches only touch the table when they already own the entry
  assign wr_en          = ctl && (taken || (is_br && ex_hit));
  always_comb begin
    wr_e.valid  = 1'b1;
    wr_e.tag    = 30'(ex_pc[31:BTB_IDX_W+2]);
    wr_e.target = taken ? target : ex_e.target;
    wr_e.ctr    = ex_hit ? (is_br ? ctr_next(ex_e.ctr, taken) : ex_e.ctr) : (is_br ? WT : ST);
  end
  btb_table #(.IDX_W(BTB_IDX_W)) u_btb (
    .clk      (clk),
    .rst      (rst),
    .rd_idx_a (if_idx),
    .rd_a     (if_e),
    .rd_idx_b (ex_idx),
    .rd_b     (ex_e),
    .wr_en    (wr_en),
    .wr_idx   (ex_idx),
    .wr_data  (wr_e)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      if_pc     <= RESET_PC;
      br_count  <= '0;
      mis_count <= '0;
    end else begin
      if_pc     <= next_pc;
      br_count  <= br_count + 32'(ctl);
      mis_count <= mis_count + 32'(mis);
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed stimulus, per-cycle model compare, literal spot checks.
module tb_branch_predict_unit;
  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;
  logic clk = 0, rst = 1, stall = 0;
  logic ex_valid = 0, ex_zero = 0, ex_pred_taken = 0;
  logic [6:0] ex_op = 0;
  logic [31:0] ex_pc = 0, ex_imm = 0, ex_rs1 = 0, ex_pred_target = 0;
  logic [31:0] if_pc, if_pred_target, br_count, mis_count;
  logic if_pred_taken, flush;
  int cmp_n = 0, err_n = 0;

  branch_predict_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .if_pred_target(if_pred_target), .ex_valid(ex_valid), .ex_op(ex_op), .ex_pc(ex_pc),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_zero(ex_zero), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .flush(flush), .br_count(br_count), .mis_count(mis_count)
  );

  always #5 clk = ~clk;

  // reference model: table as plain arrays, counters as integers 0..3
  bit          m_valid [16];
  logic [31:0] m_tag [16], m_tgt [16];
  int          m_ctr [16];
  logic [31:0] m_pc, m_br, m_mis;
  logic [3:0]  e_idx, x_idx;
  logic        e_hit, x_hit, e_pt, e_ctl, e_taken, e_mis;
  logic [31:0] e_ptgt, e_tgt, e_next;

  always_comb begin
    e_idx   = m_pc[5:2];
    e_hit   = m_valid[e_idx] && m_tag[e_idx] == (m_pc >> 6);
    e_pt    = e_hit && m_ctr[e_idx] >= 2;
    e_ptgt  = e_hit ? m_tgt[e_idx] : m_pc + 4;
    x_idx   = ex_pc[5:2];
    x_hit   = m_valid[x_idx] && m_tag[x_idx] == (ex_pc >> 6);
    e_ctl   = ex_valid && (ex_op == BR || ex_op == JAL || ex_op == JALR);
    e_taken = ex_op == BR ? ex_zero : 1'b1;
    e_tgt   = ex_op == JALR ? ((ex_rs1 + ex_imm) & 32'hFFFF_FFFE) : ex_pc + ex_imm;
    e_mis   = e_ctl && (e_taken != ex_pred_taken || (e_taken && e_tgt != ex_pred_target));
    e_next  = e_mis ? (e_taken ? e_tgt : ex_pc + 4) : stall ? m_pc : e_ptgt;
  end

  always @(posedge clk or posedge rst)
    if (rst) begin
      m_pc  <= 32'h0;
      m_br  <= 0;
      m_mis <= 0;
      for (int i = 0; i < 16; i++) begin
        m_valid[i] <= 0;
        m_tag[i]   <= 0;
        m_tgt[i]   <= 0;
        m_ctr[i]   <= 1;
      end
    end else begin
      m_pc  <= e_next;
      m_br  <= m_br + (e_ctl ? 1 : 0);
      m_mis <= m_mis + (e_mis ? 1 : 0);
      if (e_ctl && x_hit && ex_op == BR)
        m_ctr[x_idx] <= e_taken ? (m_ctr[x_idx] == 3 ? 3 : m_ctr[x_idx] + 1)
                                : (m_ctr[x_idx] == 0 ? 0 : m_ctr[x_idx] - 1);
      if (e_ctl && e_taken) begin
        m_tgt[x_idx] <= e_tgt;
        if (!x_hit) begin
          m_valid[x_idx] <= 1;
          m_tag[x_idx]   <= ex_pc >> 6;
          m_ctr[x_idx]   <= ex_op == BR ? 2 : 3;
        end
      end
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (!rst) begin
      chk("m_if_pc", if_pc, m_pc);
      chk("m_pred_taken", 32'(if_pred_taken), 32'(e_pt));
      chk("m_pred_target", if_pred_target, e_ptgt);
      chk("m_flush", 32'(flush), 32'(e_mis));
      chk("m_br_count", br_count, m_br);
      chk("m_mis_count", mis_count, m_mis);
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [31:0] pc, imm, rs1,
                       input logic zero, pt, input logic [31:0] ptgt);
    ex_valid = 1; ex_op = op; ex_pc = pc; ex_imm = imm; ex_rs1 = rs1;
    ex_zero = zero; ex_pred_taken = pt; ex_pred_target = ptgt;
    #1;
  endtask

  task automatic idle();
    ex_valid = 0; ex_op = 0; ex_pc = 0; ex_imm = 0; ex_rs1 = 0;
    ex_zero = 0; ex_pred_taken = 0; ex_pred_target = 0;
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #1;
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_pred", 32'(if_pred_taken), 0);
    chk("rst_ptgt", if_pred_target, 32'h4);
    chk("rst_flush", 32'(flush), 0);
    step(); chk("seq_4", if_pc, 32'h4);
    step(); chk("seq_8", if_pc, 32'h8);
    step(); chk("seq_c", if_pc, 32'hC);
    // taken branch at 0x10 predicted not-taken
    drive(BR, 32'h10, 32'h20, 0, 1, 0, 0);
    chk("br_flush", 32'(flush), 1);
    step(); idle();
    chk("br_redirect", if_pc, 32'h30);
    chk("br_mis1", mis_count, 1);
    // not-taken branch at 0x0C predicted taken: redirect to 0x10 to observe the new entry
    drive(BR, 32'hC, 32'h100, 0, 0, 1, 32'h10C);
    step(); idle();
    chk("look_pc", if_pc, 32'h10);
    chk("look_pred", 32'(if_pred_taken), 1);
    chk("look_tgt", if_pred_target, 32'h30);
    // three not-taken resolutions following the table: 10 -> 01 -> 00 -> 00
    drive(BR, 32'h10, 32'h20, 0, 0, 1, 32'h30);
    chk("nt1_flush", 32'(flush), 1);
    step();
    chk("nt1_pc", if_pc, 32'h14);
    drive(BR, 32'h10, 32'h20, 0, 0, 0, 32'h30);
    chk("nt2_flush", 32'(flush), 0);
    step();
    drive(BR, 32'h10, 32'h20, 0, 0, 0, 32'h30);
    chk("nt3_flush", 32'(flush), 0);
    step(); idle();
    chk("nt_mis", mis_count, 3);
    chk("nt_br", br_count, 5);
    drive(BR, 32'hC, 32'h100, 0, 0, 1, 32'h10C);
    step(); idle();
    chk("sat_pred", 32'(if_pred_taken), 0);
    chk("sat_tgt", if_pred_target, 32'h30);
    // jalr target has bit 0 cleared, then stale-target rewrite
    drive(JALR, 32'h40, 32'h0, 32'h103, 0, 0, 0);
    chk("jalr_flush", 32'(flush), 1);
    step();
    chk("jalr_pc", if_pc, 32'h102);
    drive(JALR, 32'h40, 32'h0, 32'h200, 0, 1, 32'h102);
    step();
    chk("stale_pc", if_pc, 32'h200);
    drive(JALR, 32'h40, 32'h0, 32'h103, 0, 1, 32'h200);
    chk("stale_flush", 32'(flush), 1);
    step();
    chk("fix_pc", if_pc, 32'h102);
    drive(BR, 32'h3C, 32'h0, 0, 0, 1, 0);
    step(); idle();
    chk("fix_look_pc", if_pc, 32'h40);
    chk("fix_look_pred", 32'(if_pred_taken), 1);
    chk("fix_look_tgt", if_pred_target, 32'h102);
    chk("fix_mis", mis_count, 8);
    // mispredict overrides stall; correct prediction under stall holds
    stall = 1;
    drive(JAL, 32'h24, 32'h5C, 0, 0, 0, 0);
    chk("stall_mis_flush", 32'(flush), 1);
    step();
    chk("stall_mis_pc", if_pc, 32'h80);
    drive(BR, 32'h10, 32'h20, 0, 0, 0, 0);
    chk("stall_ok_flush", 32'(flush), 0);
    step(); chk("stall_hold1", if_pc, 32'h80);
    step(); chk("stall_hold2", if_pc, 32'h80);
    idle();
    stall = 0;
    // asynchronous reset between edges
    rst = 1;
    #1;
    chk("arst_pc", if_pc, 32'h0);
    chk("arst_pred", 32'(if_pred_taken), 0);
    chk("arst_ptgt", if_pred_target, 32'h4);
    chk("arst_br", br_count, 0);
    chk("arst_mis", mis_count, 0);
    rst = 0;
    repeat (4) step();
    chk("arst_seq_pc", if_pc, 32'h10);
    chk("arst_seq_pred", 32'(if_pred_taken), 0);
    chk("arst_seq_tgt", if_pred_target, 32'h14);
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule
